// File: rtl/vend_controller.sv
// vend_controller: vending transaction FSM (credit, dispense, change/refund pulses).
// Optional stock counter and sold_out flag enabled by defining STOCK_COUNT_EN.
module vend_controller #(
    parameter int CREDIT_W        = 8,
    parameter int COIN_VALUE      = 25,
    parameter int PRICE           = 75,
    parameter int MAX_CREDIT      = 200,
    parameter int DISPENSE_CYCLES = 4,
    parameter int STOCK_INIT      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_edge,
    input  logic                select_edge,
    input  logic                cancel_edge,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                coin_return,
    output logic                coin_reject,
    output logic                busy,
    output logic                sold_out
);
    localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);
    localparam logic [CREDIT_W-1:0] CV = CREDIT_W'(COIN_VALUE);
    localparam logic [CREDIT_W-1:0] PR = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] COIN_LIMIT = CREDIT_W'(MAX_CREDIT - COIN_VALUE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISPENSE_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_DISPENSE, ST_REFUND} state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                dispense_q, coin_return_q, coin_reject_q, busy_q;
    logic                can_sel, do_cancel, do_select, coin_ok;

`ifdef STOCK_COUNT_EN
    localparam int SW = $clog2(STOCK_INIT + 1);
    logic [SW-1:0] stock_q;
    logic          sold_out_q;
    assign can_sel  = !sold_out_q;
    assign sold_out = sold_out_q;
`else
    assign can_sel  = 1'b1;
    assign sold_out = 1'b0;
`endif

    assign do_cancel = cancel_edge && credit_q != '0;
    assign do_select = !do_cancel && select_edge && can_sel && credit_q >= PR;
    // Guard against the limit before adding so the sum never wraps.
    assign coin_ok   = credit_q <= COIN_LIMIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            cnt_q         <= '0;
            dispense_q    <= 1'b0;
            coin_return_q <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef STOCK_COUNT_EN
            stock_q       <= SW'(STOCK_INIT);
            sold_out_q    <= 1'b0;
`endif
        end else begin
            coin_return_q <= 1'b0;
            coin_reject_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_CREDIT: begin
                    coin_reject_q <= coin_edge && (do_cancel || do_select || !coin_ok);
                    if (do_cancel) begin
                        state_q       <= ST_REFUND;
                        busy_q        <= 1'b1;
                        coin_return_q <= 1'b1;
                        credit_q      <= credit_q - CV;
                    end else if (do_select) begin
                        state_q    <= ST_DISPENSE;
                        busy_q     <= 1'b1;
                        dispense_q <= 1'b1;
                        cnt_q      <= '0;
                        credit_q   <= credit_q - PR;
`ifdef STOCK_COUNT_EN
                        stock_q    <= stock_q - 1'b1;
                        sold_out_q <= stock_q == SW'(1);
`endif
                    end else if (coin_edge && coin_ok) begin
                        state_q  <= ST_CREDIT;
                        credit_q <= credit_q + CV;
                    end
                end
                ST_DISPENSE: begin
                    coin_reject_q <= coin_edge;
                    if (cnt_q == CNT_LAST) begin
                        dispense_q <= 1'b0;
                        if (credit_q != '0) begin
                            state_q       <= ST_REFUND;
                            coin_return_q <= 1'b1;
                            credit_q      <= credit_q - CV;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    coin_reject_q <= coin_edge;
                    // Leave right after the final pulse; otherwise alternate pulse/gap.
                    if (credit_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!coin_return_q) begin
                        coin_return_q <= 1'b1;
                        credit_q      <= credit_q - CV;
                    end
                end
            endcase
        end
    end

    assign credit      = credit_q;
    assign dispense    = dispense_q;
    assign coin_return = coin_return_q;
    assign coin_reject = coin_reject_q;
    assign busy        = busy_q;
endmodule
